// File: rtl/pcs_tx_gearbox_mlane.sv
// Multi-lane 66b to DATA_W PCS transmit gearbox with a shared sequence counter.
// Optional sync-header checker enabled by defining PCS_TX_GEARBOX_HEAD_CHK_EN.
module pcs_tx_gearbox_mlane #(
   parameter int DATA_W  = 32,
   parameter int LANE_N  = 1,
   parameter int BLOCK_W = 64,
   parameter int CNT_N   = BLOCK_W / DATA_W,
   parameter int CNT_W   = (CNT_N > 1) ? $clog2(CNT_N) : 1,
   parameter int SEQ_W   = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [2*LANE_N-1:0]      head_i,
   input  logic [DATA_W*LANE_N-1:0] data_i,
   output logic [CNT_W-1:0]         part_o,
   output logic                     valid_o,
   output logic [DATA_W*LANE_N-1:0] data_o,
   output logic                     head_err_o
);

   localparam int RES_W = DATA_W + 2;
   localparam int CAT_W = 2 * DATA_W + 2;
   localparam int R_W   = $clog2(DATA_W + 1);

   localparam logic [SEQ_W-1:0] SEQ_STALL = SEQ_W'(32);
   localparam logic [CNT_W-1:0] PART_LAST = CNT_W'(CNT_N - 1);

   if (!(DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("pcs_tx_gearbox_mlane: DATA_W must be 16, 32 or 64");
   end

   if (LANE_N < 1) begin : g_bad_lane_n
      $error("pcs_tx_gearbox_mlane: LANE_N must be at least 1");
   end

   if (SEQ_W < 6) begin : g_bad_seq_w
      $error("pcs_tx_gearbox_mlane: SEQ_W must hold the value 32");
   end

   logic [SEQ_W-1:0]         seq_q;
   logic [CNT_W-1:0]         part_q;
   logic [R_W-1:0]           r_q;
   logic [RES_W-1:0]         res_q [LANE_N];
   logic                     valid_q;
   logic [DATA_W*LANE_N-1:0] data_q;

   logic                     stall;
   logic                     accept;
   logic                     first;
   logic [CAT_W-1:0]         res_mask;
   logic [CAT_W-1:0]         cat [LANE_N];

   assign stall   = (seq_q == SEQ_STALL);
   assign ready_o = ~stall;
   assign accept  = valid_i & ready_o;
   assign first   = (part_q == '0);

   assign part_o  = part_q;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   // New bits land above the r valid residual bits, header first.
   always_comb begin
      res_mask = (CAT_W'(1) << r_q) - CAT_W'(1);
      cat      = '{default: '0};
      for (int l = 0; l < LANE_N; l++) begin
         cat[l] = CAT_W'(res_q[l]) & res_mask;
         if (first) begin
            cat[l] = cat[l]
                   | (CAT_W'(head_i[2*l +: 2]) << r_q)
                   | (CAT_W'(data_i[l*DATA_W +: DATA_W])
                      << (r_q + R_W'(2)));
         end else begin
            cat[l] = cat[l]
                   | (CAT_W'(data_i[l*DATA_W +: DATA_W]) << r_q);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_q   <= '0;
         part_q  <= '0;
         r_q     <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         for (int l = 0; l < LANE_N; l++) begin
            res_q[l] <= '0;
         end
      end else begin
         unique case (1'b1)
            stall: begin
               seq_q   <= '0;
               r_q     <= '0;
               valid_q <= 1'b1;
               for (int l = 0; l < LANE_N; l++) begin
                  data_q[l*DATA_W +: DATA_W] <= res_q[l][DATA_W-1:0];
                  res_q[l] <= '0;
               end
            end
            accept: begin
               seq_q   <= seq_q + SEQ_W'(1);
               part_q  <= (part_q == PART_LAST) ? '0
                                                : part_q + CNT_W'(1);
               valid_q <= 1'b1;
               if (first) begin
                  r_q <= r_q + R_W'(2);
               end
               for (int l = 0; l < LANE_N; l++) begin
                  data_q[l*DATA_W +: DATA_W] <= cat[l][DATA_W-1:0];
                  res_q[l] <= cat[l][CAT_W-1:DATA_W];
               end
            end
            default: begin
               valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef PCS_TX_GEARBOX_HEAD_CHK_EN
   logic bad_head;
   logic head_err_q;

   // Only 2'b01 and 2'b10 are legal sync headers.
   always_comb begin
      bad_head = 1'b0;
      for (int l = 0; l < LANE_N; l++) begin
         if (head_i[2*l +: 2] == 2'b00 || head_i[2*l +: 2] == 2'b11) begin
            bad_head = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_err_q <= 1'b0;
      end else if (accept && first && bad_head) begin
         head_err_q <= 1'b1;
      end
   end

   assign head_err_o = head_err_q;
`else
   assign head_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_tx_gearbox_mlane.sv
// Bench for pcs_tx_gearbox_mlane: 32b x1 lane and 16b x4 lanes in lockstep,
// checked against a per-lane bitstream queue model.
`timescale 1ns/1ps
module tb_pcs_tx_gearbox_mlane;

`ifdef PCS_TX_GEARBOX_HEAD_CHK_EN
   localparam logic HC = 1'b1;
`else
   localparam logic HC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i = 1'b0;

   logic [1:0]  head_a = '0;
   logic [31:0] data_a = '0;
   logic [31:0] do_a;
   logic [0:0]  part_a;
   logic        rdy_a, vo_a, err_a;

   logic [7:0]  head_b = '0;
   logic [63:0] data_b = '0;
   logic [63:0] do_b;
   logic [1:0]  part_b;
   logic        rdy_b, vo_b, err_b;

   int total = 0;
   int bad   = 0;

   // Model state: accepted beats, stalls taken, expected outputs.
   int          nacc = 0;
   int          nstall = 0;
   logic        ev = 1'b0;
   logic [31:0] eda = '0;
   logic [63:0] edb = '0;
   logic        ea = 1'b0;
   logic        eb = 1'b0;
   bit          bq [5][$];

   always #5 clk = ~clk;

   pcs_tx_gearbox_mlane #(.DATA_W(32), .LANE_N(1)) u_a (
      .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy_a),
      .head_i(head_a), .data_i(data_a), .part_o(part_a),
      .valid_o(vo_a), .data_o(do_a), .head_err_o(err_a)
   );

   pcs_tx_gearbox_mlane #(.DATA_W(16), .LANE_N(4)) u_b (
      .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(rdy_b),
      .head_i(head_b), .data_i(data_b), .part_o(part_b),
      .valid_o(vo_b), .data_o(do_b), .head_err_o(err_b)
   );

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic badh(input logic [1:0] h);
      return (h == 2'b00) || (h == 2'b11);
   endfunction

   function automatic logic [1:0] vhead();
      return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
   endfunction

   // Each lane's serial stream: header (bit 0 first) then payload LSB first.
   task automatic push_beat(input int l, input bit hd, input logic [1:0] h,
                            input logic [31:0] d, input int w);
      if (hd) begin
         bq[l].push_back(h[0]);
         bq[l].push_back(h[1]);
      end
      for (int i = 0; i < w; i++) bq[l].push_back(d[i]);
   endtask

   task automatic pop_w(input int l, input int w, output logic [31:0] v);
      v = '0;
      for (int i = 0; i < w; i++)
         if (bq[l].size() > 0) v[i] = bq[l].pop_front();
   endtask

   task automatic model_step();
      logic [31:0] w;
      if (reset) begin
         nacc = 0; nstall = 0; ev = 1'b0;
         eda = '0; edb = '0; ea = 1'b0; eb = 1'b0;
         for (int l = 0; l < 5; l++) bq[l].delete();
      end else if (nacc == 32 * (nstall + 1)) begin
         nstall++;
         ev = 1'b1;
         pop_w(0, 32, w);
         eda = w;
         for (int l = 0; l < 4; l++) begin
            pop_w(l + 1, 16, w);
            edb[16*l +: 16] = w[15:0];
         end
      end else if (valid_i) begin
         push_beat(0, (nacc % 2) == 0, head_a, data_a, 32);
         if (HC && (nacc % 2) == 0 && badh(head_a)) ea = 1'b1;
         for (int l = 0; l < 4; l++) begin
            push_beat(l + 1, (nacc % 4) == 0, head_b[2*l +: 2],
                      {16'h0, data_b[16*l +: 16]}, 16);
            if (HC && (nacc % 4) == 0 && badh(head_b[2*l +: 2])) eb = 1'b1;
         end
         pop_w(0, 32, w);
         eda = w;
         for (int l = 0; l < 4; l++) begin
            pop_w(l + 1, 16, w);
            edb[16*l +: 16] = w[15:0];
         end
         ev = 1'b1;
         nacc++;
      end else begin
         ev = 1'b0;
      end
   endtask

   always @(posedge clk or posedge reset) model_step();

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("ready_a", 64'(rdy_a), 64'(nacc != 32 * (nstall + 1)));
         check("ready_b", 64'(rdy_b), 64'(nacc != 32 * (nstall + 1)));
         check("part_a", 64'(part_a), 64'(nacc % 2));
         check("part_b", 64'(part_b), 64'(nacc % 4));
         check("valid_a", 64'(vo_a), 64'(ev));
         check("valid_b", 64'(vo_b), 64'(ev));
         check("data_a", 64'(do_a), 64'(eda));
         check("data_b", do_b, edb);
         check("err_a", 64'(err_a), 64'(ea));
         check("err_b", 64'(err_b), 64'(eb));
      end
   end

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rnd_inputs();
      head_a = vhead();
      data_a = $urandom;
      for (int l = 0; l < 4; l++) head_b[2*l +: 2] = vhead();
      data_b = {$urandom, $urandom};
   endtask

   initial begin
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      check("rst_ready_a", 64'(rdy_a), 64'd1);
      check("rst_part_a", 64'(part_a), 64'd0);
      check("rst_valid_a", 64'(vo_a), 64'd0);
      check("rst_data_a", 64'(do_a), 64'd0);
      check("rst_ready_b", 64'(rdy_b), 64'd1);
      check("rst_part_b", 64'(part_b), 64'd0);
      check("rst_data_b", do_b, 64'd0);

      // Single part-0 beat, then a part-1 beat of zeros exposes the residual.
      rnd_inputs();
      valid_i = 1'b1;
      head_a  = 2'b01;
      data_a  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("beat0_data", 64'(do_a), 64'hFFFF_FFFD);
      check("beat0_valid", 64'(vo_a), 64'd1);
      check("beat0_part", 64'(part_a), 64'd1);
      data_a = 32'h0;
      @(negedge clk);
      check("beat1_data", 64'(do_a), 64'h3);
      valid_i = 1'b0;

      // Continuous traffic: stall exactly on cycle 32.
      pulse_reset();
      valid_i = 1'b1;
      for (int c = 0; c < 40; c++) begin
         rnd_inputs();
         check("cont_ready_a", 64'(rdy_a), 64'(c != 32));
         check("cont_ready_b", 64'(rdy_b), 64'(c != 32));
         if (c == 33) begin
            check("restart_part_a", 64'(part_a), 64'd0);
            check("restart_part_b", 64'(part_b), 64'd0);
         end
         @(negedge clk);
      end

      // Gap of three idle cycles in the middle of a block.
      pulse_reset();
      rnd_inputs();
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         check("gap_valid", 64'(vo_a), 64'd0);
         check("gap_part_a", 64'(part_a), 64'd1);
         check("gap_part_b", 64'(part_b), 64'd1);
      end
      valid_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         rnd_inputs();
         @(negedge clk);
      end

      // Invalid header on lane 2 of the 4-lane instance, then mid-block reset.
      pulse_reset();
      valid_i = 1'b1;
      head_a  = 2'b01;
      data_a  = 32'hFFFF_FFFF;
      head_b  = 8'h75;
      data_b  = {$urandom, $urandom};
      @(negedge clk);
      check("herr_set", 64'(err_b), 64'(HC));
      check("herr_other", 64'(err_a), 64'd0);
      head_b = 8'h55;
      for (int c = 0; c < 2; c++) begin
         data_a = $urandom;
         data_b = {$urandom, $urandom};
         @(negedge clk);
         check("herr_sticky", 64'(err_b), 64'(HC));
      end
      #1 reset = 1'b1;
      #1;
      check("arst_err", 64'(err_b), 64'd0);
      check("arst_valid", 64'(vo_a), 64'd0);
      check("arst_data_a", 64'(do_a), 64'd0);
      check("arst_data_b", do_b, 64'd0);
      check("arst_part_b", 64'(part_b), 64'd0);
      @(negedge clk);
      reset  = 1'b0;
      head_a = 2'b01;
      data_a = 32'hFFFF_FFFF;
      @(negedge clk);
      check("post_rst_data", 64'(do_a), 64'hFFFF_FFFD);

      // Randomised traffic with occasional bad headers and resets.
      pulse_reset();
      for (int i = 0; i < 1500; i++) begin
         rnd_inputs();
         valid_i = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) head_a = 2'($urandom);
         if ($urandom_range(0, 19) == 0) head_b = 8'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end else begin
            @(negedge clk);
         end
      end

      valid_i = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pcs_tx_gearbox_mlane.md
Name: pcs_tx_gearbox_mlane

Overview:
- Parametrised 66b→DATA_W transmit gearbox and sequence controller for LANE_N PCS lanes sharing one clock and one sequence.
- Sits between the per-lane scrambler outputs and the PMA.
- Owns the sequence counter that tells the upstream encoder which 64b block part to present.
- Generalises the single-lane 32-bit gearbox:
  - DATA_W is selectable: 16, 32 or 64.
  - Lane count is parametrised.
  - Adds a valid/ready input handshake and an output valid.

Parameters:
- DATA_W, 32, per-lane data width per cycle; legal values 16, 32, 64.
- LANE_N, 1, number of lanes; all lanes advance in lockstep.
- BLOCK_W, 64, payload bits per 66b block.
- CNT_N, BLOCK_W/DATA_W, cycles per block.
- CNT_W, max($clog2(CNT_N),1), part counter width.
- SEQ_W, 6, sequence counter width; counts 0..32.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  upstream beat valid (all lanes).
- ready_o  out  1  gearbox accepts a beat this cycle.
- head_i  in  2*LANE_N  sync header per lane; sampled only when part_o==0.
- data_i  in  DATA_W*LANE_N  scrambled payload per lane; lane l at [l*DATA_W +: DATA_W].
- part_o  out  CNT_W  block part expected on the current beat; 0 = first part, carries head.
- valid_o  out  1  data_o holds a new PMA word.
- data_o  out  DATA_W*LANE_N  PMA words per lane; LSB is transmitted first.
- head_err_o  out  1  sticky invalid-header flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async, active-high): all of the following clear to 0, immediately and regardless of clk:
  - seq_q, part_q, residual registers and residual count r;
  - valid_o, data_o, head_err_o.
- After reset: ready_o=1 and part_o=0.
- Reset mid-block discards any partial residual; the next accepted beat is treated as part 0.
- ready_o = (seq_q != 32), combinational from seq_q only; it does not depend on valid_i.
- part_o = part_q.
- accept = valid_i & ready_o.
  - On accept: seq_q += 1 and part_q = (part_q+1) mod CNT_N.
- No accept and seq_q<32 (valid_i low): hold all state; valid_o=0 next cycle; data_o holds its last value.
- Stall cycle (seq_q==32):
  - valid_i is ignored;
  - seq_q → 0;
  - each lane emits its DATA_W residual bits (r==DATA_W exactly);
  - r → 0; valid_o=1 next cycle.
- Per lane on accept:
  - part_q==0: concatenation C = {data, head, residual[r-1:0]}; r_next = r+2.
  - part_q!=0: C = {data, residual[r-1:0]}; r_next = r.
  - data_o ← C[DATA_W-1:0]; residual ← C >> DATA_W.
  - valid_o=1 next cycle.
- Latency: 1 cycle from accept to data_o/valid_o.
- Cadence: 32 accepted beats contain DATA_W/2 headers, so exactly 1 stall per 33 sequence cycles for every legal DATA_W.
  - part_q==0 is guaranteed whenever seq_q==0, because 32 is divisible by CNT_N.
- Residual storage per lane: DATA_W+2 bits; r ∈ {0,2,…,DATA_W}.
- seq_q never exceeds 32; arithmetic on seq_q is unsigned without wrap.
- Elaboration error if DATA_W ∉ {16,32,64} or LANE_N<1.

Optional Feature:
- PCS_TX_GEARBOX_HEAD_CHK_EN defined:
  - On each accept with part_q==0, any lane with head_i ∈ {2'b00, 2'b11} sets head_err_o=1 the next cycle.
  - head_err_o stays sticky until reset.
  - Data path is unaffected; the invalid header is still transmitted.
- Undefined: the checker logic is absent and head_err_o is tied 0.

Test Plan:
- Reset release, DATA_W=32, LANE_N=1 → ready_o=1, part_o=0, valid_o=0, data_o=0.
- Single beat, part 0: valid_i=1, head=2'b01, data=32'hFFFF_FFFF → next cycle valid_o=1, data_o=32'hFFFF_FFFD, part_o=1, residual=2'b11.
- Continuous valid_i for 40 cycles → ready_o low exactly on cycle 32 (0-based); the output word that cycle equals the 32 residual bits; seq_q then restarts at 0 with part_o=0.
- valid_i dropped for 3 cycles mid-block (part_o=1) → seq_q/part_q hold, valid_o=0 for those cycles, and the resumed output bitstream is identical to the gap-free run.
- DATA_W=16, LANE_N=4, distinct per-lane head/data, 66 cycles → each lane's reassembled output matches its own 66b block stream; all lanes stall on the same cycle (32).
- With PCS_TX_GEARBOX_HEAD_CHK_EN: head=2'b11 on lane 2 at part 0 → head_err_o=1 next cycle and stays high; reset asserted mid-block → head_err_o=0 and r=0 immediately.
